// File: rtl/gray2bin_tracker.sv
// gray2bin_tracker
//   Receive end of a Gray-coded counter bus (CDC pointer, encoder position).
//   The asynchronous Gray word is synchronised, decoded to binary and tracked.
//   Each accepted change is classified as a +1 step, a -1 step or an illegal
//   jump (all modulo 2^WIDTH).
//
// Parameters
//   WIDTH        bit width of the Gray input and binary output (>= 2)
//   SYNC_STAGES  synchroniser flop depth (>= 2)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   gray_in    Gray-coded word from the remote domain (asynchronous)
//   err_clr    synchronous clear of step_err
//   bin_out    decoded binary value, registered
//   bin_valid  one-cycle pulse when bin_out takes a new tracked value
//   dir        1 = last accepted step was +1, 0 = -1
//   step_err   sticky flag: an illegal jump was observed
//   tracking   high once the state machine is in TRACK
//
// Build option
//   GRAY2BIN_DIR_EN  when defined, dir reports the last step direction;
//                    when undefined, dir is tied to 0 and its register is
//                    removed (step_err behaviour is unchanged).

module gray2bin_tracker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             dir,
    output logic             step_err,
    output logic             tracking
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        UNPRIMED = 1'b0,
        TRACK    = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     prime_cnt, prime_cnt_n;
    logic [WIDTH-1:0]     sync [SYNC_STAGES];
    logic [WIDTH-1:0]     gsync;
    logic [WIDTH-1:0]     dec;
    logic [WIDTH-1:0]     bin_n;
    logic                 valid_n;
    logic                 err_n;

    // Synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync[i] <= '0;
            end
        end else begin
            sync[0] <= gray_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    assign gsync = sync[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits from i upward.
    always_comb begin
        dec = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            dec[i] = ^(gsync >> i);
        end
    end

`ifdef GRAY2BIN_DIR_EN
    logic dir_q, dir_n;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        prime_cnt_n = prime_cnt;
        bin_n       = bin_out;
        valid_n     = 1'b0;
        err_n       = step_err;
`ifdef GRAY2BIN_DIR_EN
        dir_n       = dir_q;
`endif
        if (err_clr) begin
            err_n = 1'b0;
        end
        case (state)
            UNPRIMED: begin
                bin_n = dec;
                if (prime_cnt == CNT_W'(SYNC_STAGES)) begin
                    state_n = TRACK;
                end else begin
                    prime_cnt_n = prime_cnt + CNT_W'(1);
                end
            end
            TRACK: begin
                if (dec != bin_out) begin
                    bin_n   = dec;
                    valid_n = 1'b1;
                    if (dec == bin_out + WIDTH'(1)) begin
`ifdef GRAY2BIN_DIR_EN
                        dir_n = 1'b1;
`endif
                    end else if (dec == bin_out - WIDTH'(1)) begin
`ifdef GRAY2BIN_DIR_EN
                        dir_n = 1'b0;
`endif
                    end else begin
                        // A new illegal jump overrides a coincident clear.
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = UNPRIMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= UNPRIMED;
            prime_cnt <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            state     <= state_n;
            prime_cnt <= prime_cnt_n;
            bin_out   <= bin_n;
            bin_valid <= valid_n;
            step_err  <= err_n;
        end
    end

    assign tracking = (state == TRACK);

`ifdef GRAY2BIN_DIR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_n;
        end
    end
    assign dir = dir_q;
`else
    assign dir = 1'b0;
`endif

endmodule

// File: doc/gray2bin_tracker.md
# gray2bin_tracker

Sequential Gray-to-binary decoder: the receive end of a Gray-coded counter bus, such as a CDC pointer or an encoder position.
- Synchronises an asynchronous Gray-coded word into the local clock domain and decodes it to binary.
- Checks that each change is a legal ±1 step (modulo 2^WIDTH), reports step direction and flags illegal jumps.
- Sits after any remote Gray encoder and feeds local pointer-compare or position logic.

## Interface
- WIDTH, 4, bit width of Gray input and binary output (≥2)
- SYNC_STAGES, 2, synchroniser flop depth (≥2)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- gray_in  input  WIDTH  Gray-coded word from the remote domain (asynchronous)
- err_clr  input  1  synchronous clear of step_err
- bin_out  output  WIDTH  decoded binary value, registered
- bin_valid  output  1  one-cycle pulse when bin_out takes a new tracked value
- dir  output  1  1 = last accepted step was +1, 0 = −1 (see Configuration)
- step_err  output  1  sticky flag: an illegal jump was observed
- tracking  output  1  high once the state machine is in TRACK

## Operation
- Synchroniser: SYNC_STAGES flops; gray_in enters sync[0]; the last stage is gsync. All stages reset to 0.
- Decode (combinational on gsync): b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i = WIDTH-2 down to 0.
- State machine: two states, UNPRIMED and TRACK.
  - Reset enters UNPRIMED; prime counter = 0.
- UNPRIMED:
  - Each cycle, bin_out loads the decoded value silently: no bin_valid, no error check.
  - The prime counter increments each cycle.
  - When the counter equals SYNC_STAGES, the FSM moves to TRACK on that edge.
  - tracking rises on that same edge.
- TRACK: each cycle compare nb = decode(gsync) against bin_out.
  - nb == bin_out: hold all outputs; bin_valid = 0.
  - nb == bin_out+1 mod 2^WIDTH: load nb, bin_valid = 1, dir = 1.
  - nb == bin_out−1 mod 2^WIDTH: load nb, bin_valid = 1, dir = 0.
  - Any other nb (illegal jump): load nb (resynchronise), bin_valid = 1, step_err set, dir holds.
- Wrap-around: with WIDTH=4, bin 15→0 (Gray 1000→0000) is a legal +1; bin 0→15 is a legal −1.
- err_clr clears step_err. If err_clr and a new illegal jump occur in the same cycle, set wins.
- All arithmetic is modulo 2^WIDTH; there is no saturation.
- Reset mid-operation (rst_n low) immediately forces every output and state to its reset value. Priming restarts after release.

## Timing
- Reset values: bin_out = 0, bin_valid = 0, dir = 0, step_err = 0, tracking = 0, FSM = UNPRIMED, synchroniser = 0.
- Latency: a gray_in change that is stable before edge k appears on bin_out/bin_valid at edge k+SYNC_STAGES (3 edges for default SYNC_STAGES=2, counting edge k).
- tracking rises SYNC_STAGES+1 edges after rst_n deasserts.
- bin_valid is exactly one cycle wide per accepted change. Back-to-back steps on consecutive cycles give back-to-back pulses.
- step_err asserts on the same edge as the bin_valid of the offending sample. It clears on the edge after err_clr is sampled high.
- The remote side must change gray_in by at most one Gray step per local clock. Faster input is out of scope and is reported as step_err.

## Configuration
- GRAY2BIN_DIR_EN defined: dir is computed as described above.
- Not defined:
  - dir is tied to 0.
  - Legal ±1 steps are still distinguished from illegal jumps, so step_err behaviour is unchanged.
  - The direction register is removed.

## Test plan
- Reset, gray_in = 0000 held: tracking = 1 at edge 3 after release; bin_out = 0; bin_valid never pulses; step_err = 0.
- Reset with gray_in = 0110 held: bin_out = 0100 after priming; no bin_valid, no step_err; tracking = 1.
- Full up-count, WIDTH=4, one Gray step every 4 cycles (0000→0001→0011→…→1000→0000):
  - bin_out sequences 0..15 then 0, each 3 cycles after its input.
  - 16 bin_valid pulses; dir = 1 throughout (macro on); step_err = 0.
- Down-step 0000→1000 (bin 0→15): bin_valid pulse, dir = 0, step_err = 0.
- Illegal jump 0001→0100 (bin 1→7): bin_out = 7, bin_valid = 1, step_err = 1 and held. err_clr pulse clears it. err_clr coincident with a second illegal jump leaves step_err = 1.
- Assert rst_n low mid-count at bin_out = 9: all outputs go to 0 immediately; after release the FSM re-primes to the current input with no step_err.
